// File: rtl/spi_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module : spi_fifo_ctrl
// Brief  : Bus-facing SPI controller with TX/RX FIFOs and start sequencing
//          for a word/byte shift engine.
// Rev    : 1.0  initial release
// ============================================================================
module spi_fifo_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        wr,
    input  logic        addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic [1:0]  cs_n,
    output logic        spi_start,
    output logic        spi_fast,
    output logic [31:0] spi_dataTx,
    input  logic [31:0] spi_dataRx,
    input  logic        spi_rdy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_LO = 2'd1,
        ST_WAIT_HI = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     tx_mem_q [DEPTH];
    logic [31:0]     tx_mem_d [DEPTH];
    logic [31:0]     rx_mem_q [DEPTH];
    logic [31:0]     rx_mem_d [DEPTH];
    logic [AW-1:0]   tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [AW-1:0]   rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic            fast_q, fast_d, irq_en_q, irq_en_d;
    logic [1:0]      cs_q, cs_d, cs_pend_q, cs_pend_d;
    logic            cs_pend_vld_q, cs_pend_vld_d;
    logic            tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;
    logic            discard_q, discard_d;
    logic            spi_start_q, spi_start_d, spi_fast_q, spi_fast_d;
    logic [31:0]     spi_dataTx_q, spi_dataTx_d;

    logic data_wr, data_rd, ctrl_wr, flush;
    logic tx_empty, tx_full, rx_empty, rx_full;
    logic launch, finish, tx_push, tx_pop, rx_push, rx_pop;

    assign data_wr  = sel & wr & ~addr;
    assign data_rd  = sel & ~wr & ~addr;
    assign ctrl_wr  = sel & wr & addr;
    assign flush    = ctrl_wr & wdata[4];
    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == CW'(DEPTH));
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == CW'(DEPTH));
    assign launch   = (state_q == ST_IDLE) & ~tx_empty & ~rx_full & spi_rdy;
    assign finish   = (state_q == ST_WAIT_HI) & spi_rdy;
    assign tx_pop   = launch;
    assign tx_push  = data_wr & ~flush & (~tx_full | tx_pop);
    assign rx_pop   = data_rd & ~rx_empty;
    assign rx_push  = finish & ~discard_q & ~flush;

    always_comb begin
        state_d      = state_q;
        spi_start_d  = 1'b0;
        spi_fast_d   = spi_fast_q;
        spi_dataTx_d = spi_dataTx_q;
        discard_d    = discard_q;
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    spi_start_d  = 1'b1;
                    spi_dataTx_d = tx_mem_q[tx_rp_q];
                    spi_fast_d   = fast_q;
                    state_d      = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: if (!spi_rdy) state_d = ST_WAIT_HI;
            ST_WAIT_HI: begin
                if (spi_rdy) begin
                    discard_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A flush while a word is (or is about to be) in flight drops its result
        if (flush) discard_d = (state_d != ST_IDLE);
    end

    always_comb begin
        tx_mem_d = tx_mem_q;
        rx_mem_d = rx_mem_q;
        tx_wp_d  = tx_wp_q;
        tx_rp_d  = tx_rp_q;
        rx_wp_d  = rx_wp_q;
        rx_rp_d  = rx_rp_q;
        tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
        if (tx_push) begin
            tx_mem_d[tx_wp_q] = wdata;
            tx_wp_d           = tx_wp_q + AW'(1);
        end
        if (tx_pop) tx_rp_d = tx_rp_q + AW'(1);
        if (rx_push) begin
            rx_mem_d[rx_wp_q] = spi_dataRx;
            rx_wp_d           = rx_wp_q + AW'(1);
        end
        if (rx_pop) rx_rp_d = rx_rp_q + AW'(1);
        if (flush) begin
            tx_wp_d  = '0;
            tx_rp_d  = '0;
            tx_cnt_d = '0;
            rx_wp_d  = '0;
            rx_rp_d  = '0;
            rx_cnt_d = '0;
        end
    end

    always_comb begin
        fast_d        = fast_q;
        irq_en_d      = irq_en_q;
        cs_d          = cs_q;
        cs_pend_d     = cs_pend_q;
        cs_pend_vld_d = cs_pend_vld_q;
        tx_ovf_d      = tx_ovf_q | (data_wr & ~flush & tx_full & ~tx_pop);
        rx_unf_d      = rx_unf_q | (data_rd & rx_empty);
        if (finish) begin
            cs_pend_vld_d = 1'b0;
            if (cs_pend_vld_q) cs_d = cs_pend_q;
        end
        if (ctrl_wr) begin
            fast_d   = wdata[0];
            irq_en_d = wdata[5];
            // Chip selects only move between transfers; the latest write wins
            if ((state_q == ST_IDLE) || finish) begin
                cs_d          = wdata[2:1];
                cs_pend_vld_d = 1'b0;
            end else begin
                cs_pend_d     = wdata[2:1];
                cs_pend_vld_d = 1'b1;
            end
            if (wdata[3]) begin
                tx_ovf_d = 1'b0;
                rx_unf_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                tx_mem_q[i] <= '0;
                rx_mem_q[i] <= '0;
            end
            tx_wp_q       <= '0;
            tx_rp_q       <= '0;
            rx_wp_q       <= '0;
            rx_rp_q       <= '0;
            tx_cnt_q      <= '0;
            rx_cnt_q      <= '0;
            fast_q        <= 1'b0;
            irq_en_q      <= 1'b0;
            cs_q          <= 2'b00;
            cs_pend_q     <= 2'b00;
            cs_pend_vld_q <= 1'b0;
            tx_ovf_q      <= 1'b0;
            rx_unf_q      <= 1'b0;
            discard_q     <= 1'b0;
            spi_start_q   <= 1'b0;
            spi_fast_q    <= 1'b0;
            spi_dataTx_q  <= '0;
        end else begin
            state_q       <= state_d;
            tx_mem_q      <= tx_mem_d;
            rx_mem_q      <= rx_mem_d;
            tx_wp_q       <= tx_wp_d;
            tx_rp_q       <= tx_rp_d;
            rx_wp_q       <= rx_wp_d;
            rx_rp_q       <= rx_rp_d;
            tx_cnt_q      <= tx_cnt_d;
            rx_cnt_q      <= rx_cnt_d;
            fast_q        <= fast_d;
            irq_en_q      <= irq_en_d;
            cs_q          <= cs_d;
            cs_pend_q     <= cs_pend_d;
            cs_pend_vld_q <= cs_pend_vld_d;
            tx_ovf_q      <= tx_ovf_d;
            rx_unf_q      <= rx_unf_d;
            discard_q     <= discard_d;
            spi_start_q   <= spi_start_d;
            spi_fast_q    <= spi_fast_d;
            spi_dataTx_q  <= spi_dataTx_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (addr) begin
            rdata[0]     = fast_q;
            rdata[2:1]   = cs_q;
            rdata[5]     = irq_en_q;
            rdata[8]     = tx_empty;
            rdata[9]     = tx_full;
            rdata[10]    = rx_empty;
            rdata[11]    = rx_full;
            rdata[12]    = (state_q != ST_IDLE);
            rdata[13]    = tx_ovf_q;
            rdata[15]    = rx_unf_q;
            rdata[23:16] = 8'(rx_cnt_q);
        end else if (!rx_empty) begin
            rdata = rx_mem_q[rx_rp_q];
        end
    end

    assign irq        = irq_en_q & ~rx_empty;
    assign cs_n       = ~cs_q;
    assign spi_start  = spi_start_q;
    assign spi_fast   = spi_fast_q;
    assign spi_dataTx = spi_dataTx_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_spi_fifo_ctrl
// Brief  : Directed + random bench for spi_fifo_ctrl against a queue model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_spi_fifo_ctrl;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel, wr, addr;
    logic [31:0] wdata, rdata;
    logic        irq;
    logic [1:0]  cs_n;
    logic        spi_start, spi_fast, spi_rdy;
    logic [31:0] spi_dataTx, spi_dataRx;

    always #5 clk = ~clk;

    spi_fifo_ctrl #(.DEPTH(DEPTH)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .sel        (sel),
        .wr         (wr),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .irq        (irq),
        .cs_n       (cs_n),
        .spi_start  (spi_start),
        .spi_fast   (spi_fast),
        .spi_dataTx (spi_dataTx),
        .spi_dataRx (spi_dataRx),
        .spi_rdy    (spi_rdy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: software view of FIFOs, flags and transfer progress
    logic [31:0] m_txq[$];
    logic [31:0] m_rxq[$];
    bit          m_fast, m_irq_en, m_ovf, m_unf, m_busy, m_dropped, m_discard;
    bit          m_pend_vld, m_spi_fast, m_start;
    logic [1:0]  m_cs, m_pend;
    logic [31:0] m_dataTx;
    logic [31:0] last_rdata;

    // Engine model
    int eng_cnt  = 0;
    bit eng_hold = 0;
    int n_starts = 0;

    task automatic model_reset();
        m_txq.delete();
        m_rxq.delete();
        m_fast = 0; m_irq_en = 0; m_ovf = 0; m_unf = 0; m_busy = 0;
        m_dropped = 0; m_discard = 0; m_pend_vld = 0; m_spi_fast = 0;
        m_start = 0; m_cs = 2'b00; m_pend = 2'b00; m_dataTx = '0;
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] st;
        st        = '0;
        st[0]     = m_fast;
        st[2:1]   = m_cs;
        st[5]     = m_irq_en;
        st[8]     = (m_txq.size() == 0);
        st[9]     = (m_txq.size() == DEPTH);
        st[10]    = (m_rxq.size() == 0);
        st[11]    = (m_rxq.size() == DEPTH);
        st[12]    = m_busy;
        st[13]    = m_ovf;
        st[15]    = m_unf;
        st[23:16] = 8'(m_rxq.size());
        return st;
    endfunction

    task automatic step(input logic s, input logic w, input logic a, input logic [31:0] d);
        logic        dw, dr, cw, launch, complete;
        logic [31:0] exp_rd;
        logic [1:0]  exp_csn;
        @(negedge clk);
        if (eng_cnt > 1) eng_cnt--;
        else if (eng_cnt == 1) begin
            if (!eng_hold) begin
                spi_rdy = 1'b1;
                eng_cnt = 0;
            end
        end else if (spi_start) begin
            spi_rdy    = 1'b0;
            spi_dataRx = ~spi_dataTx;
            eng_cnt    = 8;
            n_starts++;
        end else spi_rdy = !eng_hold;
        sel = s; wr = w; addr = a; wdata = d;
        #1;
        exp_rd     = a ? m_status() : ((m_rxq.size() > 0) ? m_rxq[0] : 32'h0);
        last_rdata = rdata;
        if (s && !w) check_eq(a ? "status" : "rx_data", rdata, exp_rd);

        dw       = s & w & ~a;
        dr       = s & ~w & ~a;
        cw       = s & w & a;
        launch   = !m_busy && (m_txq.size() > 0) && (m_rxq.size() < DEPTH) && spi_rdy;
        complete = m_busy && m_dropped && spi_rdy;
        m_start  = launch;
        if (launch) begin
            m_dataTx   = m_txq.pop_front();
            m_spi_fast = m_fast;
        end
        if (dw) begin
            if (m_txq.size() < DEPTH) m_txq.push_back(d);
            else m_ovf = 1;
        end
        if (dr) begin
            if (m_rxq.size() > 0) void'(m_rxq.pop_front());
            else m_unf = 1;
        end
        if (cw) begin
            m_fast   = d[0];
            m_irq_en = d[5];
            if (m_busy) begin
                m_pend     = d[2:1];
                m_pend_vld = 1;
            end else m_cs = d[2:1];
            if (d[3]) begin
                m_ovf = 0;
                m_unf = 0;
            end
        end
        if (complete) begin
            if (!m_discard) m_rxq.push_back(spi_dataRx);
            m_discard = 0;
            m_busy    = 0;
            if (m_pend_vld) begin
                m_cs       = m_pend;
                m_pend_vld = 0;
            end
        end else if (m_busy && !spi_rdy) m_dropped = 1;
        if (launch) begin
            m_busy    = 1;
            m_dropped = 0;
        end
        if (cw && d[4]) begin
            m_txq.delete();
            m_rxq.delete();
            m_discard = m_busy;
        end

        @(posedge clk);
        #1;
        exp_csn = ~m_cs;
        check_eq("spi_start", spi_start, m_start);
        check_eq("spi_dataTx", spi_dataTx, m_dataTx);
        check_eq("spi_fast", spi_fast, m_spi_fast);
        check_eq("cs_n", cs_n, exp_csn);
        check_eq("irq", irq, m_irq_en && (m_rxq.size() > 0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    int          s0;
    int          r;
    logic [31:0] rd;

    initial begin
        rst = 1'b1; sel = 0; wr = 0; addr = 0; wdata = '0;
        spi_rdy = 1'b1; spi_dataRx = '0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_cs_n", cs_n, 32'h3);
        check_eq("rst_start", spi_start, 32'h0);
        check_eq("rst_irq", irq, 32'h0);
        rst = 1'b0;

        // Reset state and quiet engine
        step(1, 0, 1, 0);
        check_eq("t1_status", last_rdata, 32'h0000_0500);
        idle(20);
        check_eq("t1_no_start", n_starts, 0);

        // Three queued words, fast mode, cs 01
        step(1, 1, 1, 32'h3);
        step(1, 1, 0, 32'h11);
        step(1, 1, 0, 32'h22);
        step(1, 1, 0, 32'h33);
        idle(50);
        check_eq("t2_starts", n_starts, 3);
        step(1, 0, 0, 0); check_eq("t2_rd0", last_rdata, 32'hFFFF_FFEE);
        step(1, 0, 0, 0); check_eq("t2_rd1", last_rdata, 32'hFFFF_FFDD);
        step(1, 0, 0, 0); check_eq("t2_rd2", last_rdata, 32'hFFFF_FFCC);
        step(1, 0, 1, 0); check_eq("t2_rx_empty", last_rdata[10], 32'h1);

        // TX overflow with the engine held busy
        eng_hold = 1;
        idle(2);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 32'h100 + i);
        step(1, 0, 1, 0);
        check_eq("t3_ovf", last_rdata[13], 32'h1);
        check_eq("t3_full", last_rdata[9], 32'h1);
        step(1, 1, 1, 32'h0B);
        step(1, 0, 1, 0);
        check_eq("t3_ovf_clr", last_rdata[13], 32'h0);
        eng_hold = 0;
        idle(60);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);

        // RX-full back-pressure
        s0 = n_starts;
        for (int i = 0; i < 6; i++) step(1, 1, 0, 32'hA0 + i);
        idle(80);
        check_eq("t4_starts4", n_starts - s0, 4);
        step(1, 0, 1, 0);
        check_eq("t4_rx_full", last_rdata[11], 32'h1);
        check_eq("t4_busy", last_rdata[12], 32'h0);
        step(1, 0, 0, 0);
        idle(3);
        check_eq("t4_starts5", n_starts - s0, 5);
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0, 0);
            idle(15);
        end
        step(1, 1, 1, 32'h0B);

        // Underflow, then flush mid-transfer
        step(1, 0, 0, 0);
        check_eq("t5_empty_rd", last_rdata, 32'h0);
        step(1, 0, 1, 0);
        check_eq("t5_unf", last_rdata[15], 32'h1);
        step(1, 1, 0, 32'hA5);
        idle(4);
        step(1, 1, 1, 32'h1B);
        idle(20);
        step(1, 0, 1, 0);
        check_eq("t5_rx_empty", last_rdata[10], 32'h1);
        check_eq("t5_tx_empty", last_rdata[8], 32'h1);

        // Mode/cs changes while busy are deferred
        step(1, 1, 1, 32'h03);
        step(1, 1, 0, 32'h1234_5678);
        idle(3);
        step(1, 1, 1, 32'h04);
        step(1, 1, 0, 32'h9);
        check_eq("t6_fast_held", spi_fast, 32'h1);
        check_eq("t6_cs_held", cs_n, 32'h2);
        idle(40);
        check_eq("t6_cs_new", cs_n, 32'h1);
        check_eq("t6_fast_new", spi_fast, 32'h0);

        // Asynchronous reset in the middle of a transfer
        step(1, 1, 0, 32'hDEAD_BEEF);
        idle(4);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_cs_n", cs_n, 32'h3);
        check_eq("mid_rst_start", spi_start, 32'h0);
        check_eq("mid_rst_fast", spi_fast, 32'h0);
        model_reset();
        eng_cnt = 0; eng_hold = 0; spi_rdy = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 1, 0);
        check_eq("mid_rst_status", last_rdata, 32'h0000_0500);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r  = $urandom_range(0, 9);
            rd = $urandom;
            if (r < 4) step(0, 0, 0, 0);
            else if (r < 6) step(1, 1, 0, rd);
            else if (r < 8) step(1, 0, 0, 0);
            else if (r == 8) step(1, 0, 1, 0);
            else step(1, 1, 1, (rd & 32'h2F) | (($urandom_range(0, 7) == 0) ? 32'h10 : 32'h0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
